// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-fed ALU framer: default widths, FSM
// state encoding and the opcode values understood by the downstream ALU.
package uart_alu_pkg;

  localparam int DEF_BUS_LEN    = 8;
  localparam int DEF_OPCODE_LEN = 6;

  typedef enum logic [2:0] {
    WAIT_OPE1,
    WAIT_OPE2,
    WAIT_OPCODE,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic [DEF_OPCODE_LEN-1:0] OP_ADD = 6'h20;
  localparam logic [DEF_OPCODE_LEN-1:0] OP_SUB = 6'h22;
  localparam logic [DEF_OPCODE_LEN-1:0] OP_AND = 6'h24;
  localparam logic [DEF_OPCODE_LEN-1:0] OP_OR  = 6'h25;
  localparam logic [DEF_OPCODE_LEN-1:0] OP_XOR = 6'h26;
  localparam logic [DEF_OPCODE_LEN-1:0] OP_NOR = 6'h27;
  localparam logic [DEF_OPCODE_LEN-1:0] OP_SRA = 6'h03;
  localparam logic [DEF_OPCODE_LEN-1:0] OP_SRL = 6'h02;

  // Partial-frame states are the only ones guarded by the inter-byte timer.
  function automatic logic in_partial_frame(input state_t s);
    return (s == WAIT_OPE2) || (s == WAIT_OPCODE);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter: counts while running, flags the terminal count
// and restarts from zero on clear, on idle, or once it has expired.
module frame_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign o_expired = i_run && (cnt == TERM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clear || !i_run || o_expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_alu_framer.sv
// Collects operand1, operand2 and opcode bytes from a UART receiver, feeds
// them to an ALU and hands the registered result to the UART transmitter.
module uart_alu_framer
  import uart_alu_pkg::*;
#(
  parameter int BUS_LEN     = DEF_BUS_LEN,
  parameter int OPCODE_LEN  = DEF_OPCODE_LEN,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [BUS_LEN-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  input  logic [BUS_LEN-1:0]    i_alu_result,
  output logic [BUS_LEN-1:0]    o_ope1,
  output logic [BUS_LEN-1:0]    o_ope2,
  output logic [OPCODE_LEN-1:0] o_opcode,
  output logic [BUS_LEN-1:0]    o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_timeout,
  output logic                  o_overrun
);

  state_t state;
  logic   send_p1;
  logic   timer_run;
  logic   expired;

  assign timer_run = in_partial_frame(state);

  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (timer_run),
    .i_clear  (i_rx_done),
    .o_expired(expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= WAIT_OPE1;
      send_p1    <= 1'b0;
      o_ope1     <= '0;
      o_ope2     <= '0;
      o_opcode   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_timeout  <= 1'b0;
      // Result is captured one edge before the start pulse so tx_data is settled.
      o_tx_start <= send_p1;
      send_p1    <= 1'b0;
      case (state)
        WAIT_OPE1: begin
          if (i_rx_done) begin
            o_ope1 <= i_rx_data;
            state  <= WAIT_OPE2;
          end
        end
        WAIT_OPE2: begin
          if (i_rx_done) begin
            o_ope2 <= i_rx_data;
            state  <= WAIT_OPCODE;
          end else if (expired) begin
            o_timeout <= 1'b1;
            state     <= WAIT_OPE1;
          end
        end
        WAIT_OPCODE: begin
          if (i_rx_done) begin
            o_opcode <= i_rx_data[OPCODE_LEN-1:0];
            state    <= SEND;
          end else if (expired) begin
            o_timeout <= 1'b1;
            state     <= WAIT_OPE1;
          end
        end
        SEND: begin
          o_tx_data <= i_alu_result;
          send_p1   <= 1'b1;
          state     <= WAIT_TX;
          if (i_rx_done) o_overrun <= 1'b1;
        end
        WAIT_TX: begin
          if (i_rx_done) o_overrun <= 1'b1;
          if (i_tx_done) state <= WAIT_OPE1;
        end
        default: state <= WAIT_OPE1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_framer.sv
// Bench for uart_alu_framer with a behavioural ALU attached and a result
// scoreboard fed at opcode time and drained on each tx start pulse.
module tb_uart_alu_framer;
  import uart_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] ope1, ope2, tx_data;
  logic [5:0] opcode;
  logic       tx_start, timeout, overrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  int timeout_seen = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [5:0] opc;
    logic [7:0] res;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  uart_alu_framer #(
    .BUS_LEN(8),
    .OPCODE_LEN(6),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_tx_done(tx_done),
    .i_alu_result(alu_result),
    .o_ope1(ope1),
    .o_ope2(ope2),
    .o_opcode(opcode),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_timeout(timeout),
    .o_overrun(overrun)
  );

  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_ADD: alu_result = ope1 + ope2;
      OP_SUB: alu_result = ope1 - ope2;
      OP_AND: alu_result = ope1 & ope2;
      OP_OR:  alu_result = ope1 | ope2;
      OP_XOR: alu_result = ope1 ^ ope2;
      OP_NOR: alu_result = ~(ope1 | ope2);
      OP_SRA: alu_result = 8'($signed(ope1) >>> ope2);
      OP_SRL: alu_result = ope1 >> ope2;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (timeout === 1'b1) timeout_seen++;
    if (rst_n && tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_tx_start: got tx_data 0x%0h, want no start", tx_data);
      end else begin
        check("tx_data", tx_data, exp_q.pop_front());
      end
    end
  end

  // Precondition: called at a negedge. Returns one negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
  endtask

  // Called right after send_byte(opcode): now just past edge N+1.
  task automatic finish_frame(input logic [5:0] exp_opc, input bit do_done);
    check("opcode", opcode, exp_opc);
    check("tx_start_n1", tx_start, 1'b0);
    @(negedge clk);
    check("tx_start_n2", tx_start, 1'b1);
    @(negedge clk);
    check("tx_start_n3", tx_start, 1'b0);
    if (do_done) pulse_tx_done();
  endtask

  task automatic run_frame(input vec_t v, input bit do_done);
    send_byte(v.a);
    send_byte(v.b);
    exp_q.push_back(v.res);
    send_byte(v.op);
    check("ope1", ope1, v.a);
    check("ope2", ope2, v.b);
    finish_frame(v.opc, do_done);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ope1"}, ope1, 0);
    check({tag, "_ope2"}, ope2, 0);
    check({tag, "_opcode"}, opcode, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int seen0;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vecs[1] = '{8'h05, 8'h07, 8'hE2, 6'h22, 8'hFE};
    vecs[2] = '{8'h0F, 8'h01, 8'h24, 6'h24, 8'h01};
    vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
    vecs[4] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
    vecs[5] = '{8'h80, 8'h02, 8'h03, 6'h03, 8'hE0};
    vecs[6] = '{8'h80, 8'h02, 8'hC2, 6'h02, 8'h20};
    vecs[7] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
    vecs[8] = '{8'h00, 8'h00, 8'h27, 6'h27, 8'hFF};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_frame(vecs[i], 1'b1);

    // tx_done outside WAIT_TX must be ignored
    pulse_tx_done();
    send_byte(8'h09);
    pulse_tx_done();
    send_byte(8'h04);
    exp_q.push_back(8'h05);
    send_byte(8'h22);
    finish_frame(6'h22, 1'b1);

    // Byte arriving while a result is pending
    check("overrun_clear", overrun, 1'b0);
    run_frame('{8'h05, 8'h03, 8'h20, 6'h20, 8'h08}, 1'b0);
    send_byte(8'h11);
    check("overrun_set", overrun, 1'b1);
    check("overrun_ope1", ope1, 8'h05);
    check("overrun_ope2", ope2, 8'h03);
    check("overrun_tx_data", tx_data, 8'h08);
    pulse_tx_done();
    run_frame('{8'h0F, 8'h01, 8'h24, 6'h24, 8'h01}, 1'b1);
    check("overrun_sticky", overrun, 1'b1);

    // Timeout after a lone first operand
    send_byte(8'h05);
    k = 1;
    while (timeout !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 16);
    check("timeout_ope1_kept", ope1, 8'h05);
    @(negedge clk);
    check("timeout_pulse_len", timeout, 1'b0);
    run_frame('{8'h0A, 8'h02, 8'h22, 6'h22, 8'h08}, 1'b1);

    // Second operand exactly at the terminal count wins over the timeout
    seen0 = timeout_seen;
    send_byte(8'h05);
    repeat (14) @(negedge clk);
    rx_data = 8'h07;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("term_no_timeout", timeout, 1'b0);
    check("term_ope2", ope2, 8'h07);
    @(negedge clk);
    exp_q.push_back(8'h0C);
    send_byte(8'h20);
    finish_frame(6'h20, 1'b1);
    check("term_timeout_count", timeout_seen - seen0, 0);

    // Reset between second operand and opcode
    send_byte(8'h0F);
    send_byte(8'h01);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_no_start", tx_start, 1'b0);
    run_frame('{8'h0F, 8'h01, 8'h24, 6'h24, 8'h01}, 1'b1);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_alu_framer.md
UART_ALU_FRAMER -- requirements
Module: uart_alu_framer

Interface
REQ-001 The block SHALL have parameter BUS_LEN, default 8, the operand/result width (equals UART data width).
REQ-002 The block SHALL have parameter OPCODE_LEN, default 6, the opcode width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 50000, the inter-byte timeout in clock cycles (>=2).
REQ-004 The block SHALL have port i_clk  in  1  the single clock; all logic rises on posedge.
REQ-005 The block SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_rx_data  in  BUS_LEN  the byte from the UART receiver, valid while i_rx_done is high.
REQ-007 The block SHALL have port i_rx_done  in  1  one-cycle pulse marking a received byte.
REQ-008 The block SHALL have port i_tx_done  in  1  one-cycle pulse from the UART transmitter marking end of the byte.
REQ-009 The block SHALL have port i_alu_result  in  BUS_LEN  the combinational result of the downstream ALU stage.
REQ-010 The block SHALL have port o_ope1  out  BUS_LEN  registered operand 1 to the ALU.
REQ-011 The block SHALL have port o_ope2  out  BUS_LEN  registered operand 2 to the ALU.
REQ-012 The block SHALL have port o_opcode  out  OPCODE_LEN  registered opcode to the ALU.
REQ-013 The block SHALL have port o_tx_data  out  BUS_LEN  registered byte to the UART transmitter.
REQ-014 The block SHALL have port o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-015 The block SHALL have port o_timeout  out  1  one-cycle pulse when a partial frame is abandoned.
REQ-016 The block SHALL have port o_overrun  out  1  sticky flag: a byte arrived while a result was pending.

Function
REQ-017 The FSM SHALL have states WAIT_OPE1, WAIT_OPE2, WAIT_OPCODE, SEND, WAIT_TX.
REQ-018 In WAIT_OPE1, on i_rx_done the block SHALL latch i_rx_data into o_ope1 and go to WAIT_OPE2.
REQ-019 In WAIT_OPE2, on i_rx_done the block SHALL latch i_rx_data into o_ope2 and go to WAIT_OPCODE.
REQ-020 In WAIT_OPCODE, on i_rx_done the block SHALL latch i_rx_data[OPCODE_LEN-1:0] into o_opcode, discarding upper bits, and go to SEND.
REQ-021 In SEND (exactly one cycle) the block SHALL register i_alu_result into o_tx_data, assert o_tx_start for that next cycle only, and go to WAIT_TX.
REQ-022 Latency SHALL be fixed: opcode i_rx_done sampled at edge N -> o_tx_start high between edges N+2 and N+3.
REQ-023 In WAIT_TX, on i_tx_done the block SHALL return to WAIT_OPE1; i_tx_done in any other state SHALL be ignored.
REQ-024 o_ope1, o_ope2, o_opcode SHALL hold their values until overwritten by the next frame, keeping the ALU result stable during transmission.
REQ-025 i_rx_done in SEND or WAIT_TX SHALL discard the byte, leave all registers unchanged and set o_overrun, which stays high until reset.
REQ-026 In WAIT_OPE2 and WAIT_OPCODE a cycle counter SHALL increment every cycle and clear on i_rx_done or state entry; it is idle elsewhere.
REQ-027 When the counter reaches TIMEOUT_CYC-1 without i_rx_done, the block SHALL pulse o_timeout one cycle and go to WAIT_OPE1; operand registers keep their values.
REQ-028 If i_rx_done coincides with the terminal count, the byte SHALL be accepted and no timeout SHALL occur.
REQ-029 The counter width SHALL be $clog2(TIMEOUT_CYC); no wrap-around is reachable.

Reset
REQ-030 On i_rst_n low, asynchronously, state SHALL be WAIT_OPE1 and counter, o_ope1, o_ope2, o_opcode, o_tx_data, o_tx_start, o_timeout, o_overrun SHALL be 0.
REQ-031 Reset asserted mid-frame or mid-transmission SHALL abandon the frame; no o_tx_start SHALL follow release until a full new frame arrives.

Structure
REQ-032 State encoding, default BUS_LEN/OPCODE_LEN and the opcode constants SHALL live in shared package uart_alu_pkg.
REQ-033 The timeout counter SHALL be a sub-module frame_timer (inputs i_clk, i_rst_n, i_run, i_clear; output o_expired).

Verification
REQ-034 Bytes 0x05, 0x03, 0x20 with ALU stage attached -> o_opcode=6'h20, o_tx_data=0x08, o_tx_start one pulse exactly two edges after third i_rx_done.
REQ-035 Bytes 0x05, 0x07, 0xE2 -> o_opcode=6'h22 (upper bits dropped), o_tx_data=0xFE.
REQ-036 Byte 0x11 injected during WAIT_TX -> o_overrun=1, o_ope1 unchanged, after i_tx_done next frame processed normally.
REQ-037 TIMEOUT_CYC=16, send 0x05 only -> o_timeout pulse 16 cycles later, state WAIT_OPE1; i_rx_done exactly at terminal count -> no timeout, byte taken as ope2.
REQ-038 Reset pulse between ope2 and opcode -> all outputs 0, following 0x0F, 0x01, 0x24 -> o_tx_data=0x01.
